intg_seq_ctrl: RTL and testbench

- Sequencer for the integrator datapath (constant multiplier, then adder/accumulator register).
- Replaces free-running ripple-counter window generation with an explicit FSM.
- Produces a one-cycle accumulator clear, then accumulates exactly WIN_LEN valid samples, then flags the result and idles GAP_LEN cycles before the next window.
- Start/stop control from a host; window counter for software/debug.

---
 rtl/intg_pkg.sv | 20 ++
 rtl/intg_mod_counter.sv | 28 ++
 rtl/intg_seq_ctrl.sv | 114 +++++++++++
 tb/tb_intg_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intg_pkg.sv
// Shared definitions for the integrator controller and datapath: state
// encoding, default window timing and the datapath widths.
package intg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } intg_state_e;

  localparam int WIN_LEN_DEF = 4;
  localparam int GAP_LEN_DEF = 2;

  // Constant-multiplier product and accumulator sum widths
  localparam int PROD_W = 9;
  localparam int SUM_W  = 13;

endpackage

// File: rtl/intg_mod_counter.sv
// Loadable, enabled up-counter with a terminal-count flag; wraps naturally
// at 2**W. Load has priority over enable.
module intg_mod_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         acc_rst2,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge CLK or posedge acc_rst2) begin
    if (acc_rst2) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  assign tc = (q == tc_val);

endmodule

// File: rtl/intg_seq_ctrl.sv
// Integrator window sequencer: one-cycle accumulator clear, WIN_LEN accepted
// samples, one-cycle result flag, GAP_LEN idle cycles, repeat until stop.
module intg_seq_ctrl
  import intg_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int GAP_LEN = GAP_LEN_DEF,
  parameter int CNT_W   = 4,
  parameter int WCNT_W  = 8
) (
  input  logic              CLK,
  input  logic              acc_rst2,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_valid,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              result_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_idx,
  output logic [WCNT_W-1:0] window_cnt
);

  localparam logic [CNT_W-1:0] SAMP_TC = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  intg_state_e state, state_nxt;

  logic             samp_ld;
  logic             samp_tc;
  logic             gap_ld;
  logic             gap_en;
  logic             gap_tc;
  logic [CNT_W-1:0] gap_cnt_unused;

  always_ff @(posedge CLK or posedge acc_rst2) begin
    if (acc_rst2) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stop has priority over every other transition out of a non-idle state
  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
    samp_ld   = 1'b0;
    gap_ld    = 1'b0;
    gap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        samp_ld   = 1'b1;
        state_nxt = stop ? ST_IDLE : ST_ACCUM;
      end
      ST_ACCUM: begin
        acc_en = sample_valid & ~stop;
        if (stop)                   state_nxt = ST_IDLE;
        else if (acc_en && samp_tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        gap_ld = 1'b1;
        if (stop)             state_nxt = ST_IDLE;
        else if (GAP_LEN > 0) state_nxt = ST_GAP;
        else                  state_nxt = ST_CLEAR;
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (stop)        state_nxt = ST_IDLE;
        else if (gap_tc) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  intg_mod_counter #(.W(CNT_W)) u_samp_cnt (
    .CLK      (CLK),
    .acc_rst2 (acc_rst2),
    .ld       (samp_ld),
    .ld_val   ('0),
    .en       (acc_en),
    .tc_val   (SAMP_TC),
    .q        (sample_idx),
    .tc       (samp_tc)
  );

  // Gap position is only consumed through its terminal-count flag
  intg_mod_counter #(.W(CNT_W)) u_gap_cnt (
    .CLK      (CLK),
    .acc_rst2 (acc_rst2),
    .ld       (gap_ld),
    .ld_val   ('0),
    .en       (gap_en),
    .tc_val   (GAP_TC),
    .q        (gap_cnt_unused),
    .tc       (gap_tc)
  );

  always_ff @(posedge CLK or posedge acc_rst2) begin
    if (acc_rst2) begin
      window_cnt <= '0;
    end else if (state == ST_DONE) begin
      window_cnt <= window_cnt + WCNT_W'(1);
    end
  end

  assign acc_clr      = (state == ST_CLEAR);
  assign result_valid = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_intg_seq_ctrl.sv
// Bench for intg_seq_ctrl: three configurations (4/2, 4/0, 16/2) share
// stimulus; a window-level reference model plus a table and corner sequences.
module tb_intg_seq_ctrl;

  logic       CLK = 1'b0;
  logic       acc_rst2 = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] xin = 4'd0;

  logic       acc_en_w[3];
  logic       acc_clr_w[3];
  logic       result_valid_w[3];
  logic       busy_w[3];
  logic [3:0] sample_idx_w[3];
  logic [7:0] window_cnt_w[3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  intg_seq_ctrl #(.WIN_LEN(4), .GAP_LEN(2), .CNT_W(4), .WCNT_W(8)) dut_a (
    .CLK(CLK), .acc_rst2(acc_rst2), .start(start), .stop(stop),
    .sample_valid(sample_valid), .acc_en(acc_en_w[0]), .acc_clr(acc_clr_w[0]),
    .result_valid(result_valid_w[0]), .busy(busy_w[0]),
    .sample_idx(sample_idx_w[0]), .window_cnt(window_cnt_w[0]));

  intg_seq_ctrl #(.WIN_LEN(4), .GAP_LEN(0), .CNT_W(4), .WCNT_W(8)) dut_b (
    .CLK(CLK), .acc_rst2(acc_rst2), .start(start), .stop(stop),
    .sample_valid(sample_valid), .acc_en(acc_en_w[1]), .acc_clr(acc_clr_w[1]),
    .result_valid(result_valid_w[1]), .busy(busy_w[1]),
    .sample_idx(sample_idx_w[1]), .window_cnt(window_cnt_w[1]));

  intg_seq_ctrl #(.WIN_LEN(16), .GAP_LEN(2), .CNT_W(4), .WCNT_W(8)) dut_c (
    .CLK(CLK), .acc_rst2(acc_rst2), .start(start), .stop(stop),
    .sample_valid(sample_valid), .acc_en(acc_en_w[2]), .acc_clr(acc_clr_w[2]),
    .result_valid(result_valid_w[2]), .busy(busy_w[2]),
    .sample_idx(sample_idx_w[2]), .window_cnt(window_cnt_w[2]));

  // Datapath stand-in for dut_a: constant multiply by 25, then accumulate
  logic [12:0] acc = 13'd0;
  always_ff @(posedge CLK) begin
    if (acc_clr_w[0])     acc <= 13'd0;
    else if (acc_en_w[0]) acc <= acc + 13'(25 * xin);
  end

  // Reference model: a window is "clear slot, WIN_LEN accepted samples,
  // done slot, GAP_LEN gap slots"; tail = -1 while collecting samples.
  int win_p[3] = '{4, 4, 16};
  int gap_p[3] = '{2, 0, 2};
  string nm[3] = '{"dut_a", "dut_b", "dut_c"};
  int m_run[3], m_clr[3], m_tail[3], m_idx[3], m_wc[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_clr[i] = 0; m_tail[i] = -1; m_idx[i] = 0; m_wc[i] = 0;
    end
  endfunction

  function automatic logic [15:0] model_exp(int i);
    logic en, clr, rv, bz;
    bz  = (m_run[i] != 0);
    clr = bz && (m_clr[i] != 0);
    rv  = bz && (m_clr[i] == 0) && (m_tail[i] == 0);
    en  = bz && (m_clr[i] == 0) && (m_tail[i] < 0) && sample_valid && !stop;
    return {en, clr, rv, bz, 4'(m_idx[i] % 16), 8'(m_wc[i] % 256)};
  endfunction

  function automatic void model_update(int i);
    if (m_run[i] == 0) begin
      if (start && !stop) begin m_run[i] = 1; m_clr[i] = 1; m_tail[i] = -1; end
    end else if (stop) begin
      if (m_clr[i] != 0) m_idx[i] = 0;
      else if (m_tail[i] == 0) m_wc[i]++;
      m_run[i] = 0; m_clr[i] = 0; m_tail[i] = -1;
    end else if (m_clr[i] != 0) begin
      m_idx[i] = 0; m_clr[i] = 0; m_tail[i] = -1;
    end else if (m_tail[i] < 0) begin
      if (sample_valid) begin
        m_idx[i]++;
        if (m_idx[i] == win_p[i]) m_tail[i] = 0;
      end
    end else if (m_tail[i] == 0) begin
      m_wc[i]++;
      if (gap_p[i] == 0) begin m_clr[i] = 1; m_tail[i] = -1; end
      else m_tail[i] = 1;
    end else if (m_tail[i] == gap_p[i]) begin
      m_clr[i] = 1; m_tail[i] = -1;
    end else begin
      m_tail[i]++;
    end
  endfunction

  function automatic logic [15:0] act(int i);
    return {acc_en_w[i], acc_clr_w[i], result_valid_w[i], busy_w[i],
            sample_idx_w[i], window_cnt_w[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, a, e);
    end
  endtask

  // Called at a falling edge: apply inputs, then compare against the model
  task automatic drive(input logic s, input logic p, input logic v, input logic [3:0] x);
    start = s; stop = p; sample_valid = v; xin = x;
    #1;
    for (int i = 0; i < 3; i++) check({"model_", nm[i]}, 32'(act(i)), 32'(model_exp(i)));
  endtask

  task automatic advance();
    @(posedge CLK);
    for (int i = 0; i < 3; i++) model_update(i);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    acc_rst2 = 1'b1;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    acc_rst2 = 1'b0;
  endtask

  typedef struct packed {
    logic        s, p, v;
    logic [3:0]  x;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t row(logic s, logic p, logic v, logic [3:0] x, logic en,
                               logic clr, logic rv, logic bz, logic [3:0] idx, logic [7:0] wc);
    vec_t r;
    r.s = s; r.p = p; r.v = v; r.x = x; r.exp = {en, clr, rv, bz, idx, wc};
    return r;
  endfunction

  vec_t tbl[17];
  int   cnt_rv;
  logic seen_b, seen_c, prev_rv_b, wrap_hit;

  initial begin
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) check({"pre_edge_", nm[i]}, 32'(act(i)), 32'h0);
    @(negedge CLK);
    acc_rst2 = 1'b0;

    //            s  p  v  x    en clr rv bz idx wc
    tbl[0]  = row(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = row(0, 0, 1, 0,   0, 1, 0, 1, 0, 0);
    tbl[2]  = row(0, 0, 1, 10,  1, 0, 0, 1, 0, 0);
    tbl[3]  = row(0, 0, 1, 5,   1, 0, 0, 1, 1, 0);
    tbl[4]  = row(0, 0, 1, 12,  1, 0, 0, 1, 2, 0);
    tbl[5]  = row(0, 0, 1, 1,   1, 0, 0, 1, 3, 0);
    tbl[6]  = row(0, 0, 1, 0,   0, 0, 1, 1, 4, 0);
    tbl[7]  = row(0, 0, 1, 0,   0, 0, 0, 1, 4, 1);
    tbl[8]  = row(0, 0, 1, 0,   0, 0, 0, 1, 4, 1);
    tbl[9]  = row(0, 0, 1, 0,   0, 1, 0, 1, 4, 1);
    tbl[10] = row(0, 0, 0, 0,   0, 0, 0, 1, 0, 1);
    tbl[11] = row(0, 0, 1, 0,   1, 0, 0, 1, 0, 1);
    tbl[12] = row(0, 0, 1, 0,   1, 0, 0, 1, 1, 1);
    tbl[13] = row(0, 1, 1, 0,   0, 0, 0, 1, 2, 1);
    tbl[14] = row(0, 0, 1, 0,   0, 0, 0, 0, 2, 1);
    tbl[15] = row(1, 1, 0, 0,   0, 0, 0, 0, 2, 1);
    tbl[16] = row(0, 0, 0, 0,   0, 0, 0, 0, 2, 1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].x);
      check($sformatf("table_row%0d", i), 32'(act(0)), 32'(tbl[i].exp));
      if (i == 6) check("acc_sum_700", 32'(acc), 32'd700);
      advance();
    end

    // Gapped valid pattern, then stop while the result is flagged
    drive(1, 0, 0, 0); advance();
    drive(0, 0, 0, 0); advance();
    begin
      logic [6:0] pat = 7'b1011001;
      int n = 0;
      for (int k = 0; k < 7; k++) begin
        drive(0, 0, pat[k], 0);
        check("gapped_idx", 32'(sample_idx_w[0]), 32'(n));
        check("gapped_en", 32'(acc_en_w[0]), 32'(pat[k]));
        n += int'(pat[k]);
        advance();
      end
    end
    drive(0, 1, 0, 0);
    check("done_after_4th_valid", 32'(result_valid_w[0]), 32'd1);
    check("done_idx", 32'(sample_idx_w[0]), 32'd4);
    advance();
    drive(0, 0, 0, 0);
    check("stop_done_idle", 32'(busy_w[0]), 32'd0);
    check("stop_done_wcnt", 32'(window_cnt_w[0]), 32'd2);
    advance();

    // Asynchronous reset in the middle of a window
    drive(1, 0, 1, 0); advance();
    drive(0, 0, 1, 0); advance();
    drive(0, 0, 1, 0); advance();
    drive(0, 0, 1, 0); advance();
    drive(0, 0, 1, 0);
    check("pre_reset_idx", 32'(sample_idx_w[0]), 32'd2);
    start = 1'b0;
    acc_rst2 = 1'b1;
    model_reset();
    #1;
    check("async_reset_outs", 32'(act(0)), 32'h0);
    advance();
    acc_rst2 = 1'b0;
    drive(0, 0, 1, 0);
    check("post_reset_outs", 32'(act(0)), 32'h0);
    advance();

    // GAP_LEN=0 goes straight to CLEAR; WIN_LEN=16 wraps sample_idx at DONE
    seen_b = 1'b0; seen_c = 1'b0; prev_rv_b = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive(k == 0, 0, 1, 0);
      if (prev_rv_b && !seen_b) begin
        check("gap0_clear_next", 32'(acc_clr_w[1]), 32'd1);
        seen_b = 1'b1;
      end
      if (result_valid_w[2] && !seen_c) begin
        check("win16_idx_wrap", 32'(sample_idx_w[2]), 32'd0);
        seen_c = 1'b1;
      end
      prev_rv_b = result_valid_w[1];
      advance();
    end
    check("gap0_seen", 32'(seen_b), 32'd1);
    check("win16_seen", 32'(seen_c), 32'd1);

    // 256 completed windows wrap window_cnt
    do_reset();
    cnt_rv = 0; wrap_hit = 1'b0;
    for (int k = 0; k < 2000 && !wrap_hit; k++) begin
      drive(k == 0, 0, 1, 0);
      if (result_valid_w[1]) begin
        cnt_rv++;
        if (cnt_rv == 256) begin
          check("wcnt_before_wrap", 32'(window_cnt_w[1]), 32'd255);
          advance();
          drive(0, 0, 1, 0);
          check("wcnt_wrap", 32'(window_cnt_w[1]), 32'd0);
          wrap_hit = 1'b1;
        end
      end
      advance();
    end
    check("wcnt_wrap_reached", 32'(wrap_hit), 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0,
            $urandom_range(9, 0) < 7, 4'($urandom_range(15, 0)));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
